// File: rtl/riscv_pkg.sv
// Shared core types: register-file geometry, the write-back entry format
// and the result of a decode-side forwarding lookup.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] location;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef struct packed {
    logic            pending;
    logic [XLEN-1:0] data;
  } fwd_t;

endpackage

// File: rtl/wq_fifo.sv
// Circular write-back buffer with per-entry valid bits; every slot is exposed
// read-only so the owner can run its own age-ordered searches.
module wq_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  wb_entry_t                 push_entry_i,
  input  logic                      pop_i,
  output wb_entry_t [DEPTH-1:0]     entries_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [$clog2(DEPTH)-1:0]  head_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push_s, do_pop_s;

  // Next-state: pushes and pops are gated here so count stays within 0..DEPTH.
  always_comb begin
    do_push_s = push_i && (count_q != FULL_CNT);
    do_pop_s  = pop_i && (count_q != '0);
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (do_pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (do_push_s) begin
      entries_d[tail_q] = push_entry_i;
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every queued write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign entries_o = entries_q;
  assign valid_o   = valid_q;
  assign head_o    = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/wq_fifo_chk.sv
// Occupancy checker for the write queue: count must stay in 0..DEPTH and the
// queue must never be asked to push when full or pop when empty.
module wq_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    push_i,
  input logic                    pop_i,
  input logic [$clog2(DEPTH):0]  count_i
);

  localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH)+1)'(DEPTH);

  a_count_range: assert property (@(posedge clk) disable iff (reset) count_i <= FULL_CNT);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push_i |-> (count_i != FULL_CNT));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) pop_i |-> (count_i != '0));

endmodule

// File: rtl/regfile_write_queue.sv
// Write-side front end of the register file: queues write-backs, drains one per
// cycle onto the single write port and forwards pending values to decode.
module regfile_write_queue
  import riscv_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_location,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     rf_stall,
  output logic                     rf_write_enabled,
  output logic [ADDR_W-1:0]        rf_write_location,
  output logic [WIDTH-1:0]         rf_write_data,
  input  logic [ADDR_W-1:0]        rd1_location,
  output logic                     rd1_pending,
  output logic [WIDTH-1:0]         rd1_fwd_data,
  input  logic [ADDR_W-1:0]        rd2_location,
  output logic                     rd2_pending,
  output logic [WIDTH-1:0]         rd2_fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_s;
  logic [DEPTH-1:0]      valid_s;
  logic [PTR_W-1:0]      head_s;
  logic [PTR_W:0]        count_s;
  wb_entry_t             push_entry_s;
  wb_entry_t             head_entry_s;
  logic                  enqueue_s;
  logic                  pop_s;
  fwd_t                  rd1_s, rd2_s;

  // Walk oldest to youngest so the youngest matching entry overwrites older ones.
  function automatic fwd_t fwd_lookup(input wb_entry_t [DEPTH-1:0] ent,
                                      input logic [DEPTH-1:0]      vld,
                                      input logic [PTR_W-1:0]      head,
                                      input logic [ADDR_W-1:0]     loc);
    fwd_t             res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (vld[idx] && (ent[idx].location == loc) && (loc != '0)) begin
        res.pending = 1'b1;
        res.data    = ent[idx].data;
      end
    end
    return res;
  endfunction

  assign in_ready     = (count_s != FULL_CNT);
  assign enqueue_s    = in_valid && in_ready && (in_location != '0);
  assign pop_s        = (count_s != '0) && !rf_stall;
  assign push_entry_s = '{location: in_location, data: in_data};
  assign head_entry_s = entries_s[head_s];

  wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (enqueue_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .entries_o    (entries_s),
    .valid_o      (valid_s),
    .head_o       (head_s),
    .count_o      (count_s)
  );

  wq_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .push_i  (enqueue_s),
    .pop_i   (pop_s),
    .count_i (count_s)
  );

  // Present the head entry to the register file; zeros when idle.
  always_comb begin
    rf_write_enabled  = pop_s;
    rf_write_location = '0;
    rf_write_data     = '0;
    if (count_s != '0) begin
      rf_write_location = head_entry_s.location;
      rf_write_data     = head_entry_s.data;
    end else begin
      rf_write_location = '0;
      rf_write_data     = '0;
    end
  end

  assign rd1_s        = fwd_lookup(entries_s, valid_s, head_s, rd1_location);
  assign rd2_s        = fwd_lookup(entries_s, valid_s, head_s, rd2_location);
  assign rd1_pending  = rd1_s.pending;
  assign rd1_fwd_data = rd1_s.data;
  assign rd2_pending  = rd2_s.pending;
  assign rd2_fwd_data = rd2_s.data;
  assign count        = count_s;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a write-order scoreboard.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_location;
  logic [31:0] in_data;
  logic        rf_stall;
  logic        rf_write_enabled;
  logic [4:0]  rf_write_location;
  logic [31:0] rf_write_data;
  logic [4:0]  rd1_location;
  logic        rd1_pending;
  logic [31:0] rd1_fwd_data;
  logic [4:0]  rd2_location;
  logic        rd2_pending;
  logic [31:0] rd2_fwd_data;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  loc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic accepted   = 1'b0;

  always #5 clk = ~clk;

  regfile_write_queue dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_location       (in_location),
    .in_data           (in_data),
    .rf_stall          (rf_stall),
    .rf_write_enabled  (rf_write_enabled),
    .rf_write_location (rf_write_location),
    .rf_write_data     (rf_write_data),
    .rd1_location      (rd1_location),
    .rd1_pending       (rd1_pending),
    .rd1_fwd_data      (rd1_fwd_data),
    .rd2_location      (rd2_location),
    .rd2_pending       (rd2_pending),
    .rd2_fwd_data      (rd2_fwd_data),
    .count             (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the write port at negedge, record any accepted request,
  // then return just after the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("count_vs_model", 64'(count), 64'(sb.size()));
    if (sb.size() == 0) begin
      chk("idle_no_write", rf_write_enabled, 1'b0);
    end else begin
      chk("drain_we", rf_write_enabled, !rf_stall);
      if (rf_write_enabled) begin
        e = sb.pop_front();
        chk("wr_loc", rf_write_location, e.loc);
        chk("wr_data", rf_write_data, e.data);
      end
    end
    accepted = !reset && in_valid && in_ready;
    if (accepted && (in_location != 5'd0)) begin
      e.loc  = in_location;
      e.data = in_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] loc, input logic [31:0] d);
    in_valid    = 1'b1;
    in_location = loc;
    in_data     = d;
    tick();
    in_valid    = 1'b0;
  endtask

  initial begin
    int idx;
    reset        = 1'b1;
    in_valid     = 1'b1;
    in_location  = 5'd3;
    in_data      = 32'h1234;
    rf_stall     = 1'b0;
    rd1_location = 5'd0;
    rd2_location = 5'd0;

    // Reset held with a request present: nothing accepted, outputs idle.
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_we", rf_write_enabled, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_loc", rf_write_location, 5'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_rd1_pending", rd1_pending, 1'b0);
    chk("rst_rd1_fwd", rd1_fwd_data, 32'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;

    // Single write: issued the cycle after acceptance.
    push(5'd5, 32'hDEADBEEF);
    chk("lat_count", count, 3'd1);
    chk("lat_we", rf_write_enabled, 1'b1);
    chk("lat_loc", rf_write_location, 5'd5);
    chk("lat_data", rf_write_data, 32'hDEADBEEF);
    tick();
    chk("lat_drained", count, 3'd0);

    // Fill under stall, attempt a fifth push, then drain in order.
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 17));
    chk("full_count", count, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    in_valid    = 1'b1;
    in_location = 5'd9;
    in_data     = 32'h99;
    tick();
    in_valid = 1'b0;
    chk("full_block_accept", accepted, 1'b0);
    chk("full_block_count", count, 3'd4);
    rf_stall = 1'b0;
    repeat (4) tick();
    chk("order_drained", count, 3'd0);

    // Forwarding: youngest match wins, no same-cycle bypass.
    rf_stall = 1'b1;
    push(5'd7, 32'hA);
    rd1_location = 5'd7;
    rd2_location = 5'd8;
    in_valid     = 1'b1;
    in_location  = 5'd7;
    in_data      = 32'hB;
    #1;
    chk("no_bypass_fwd", rd1_fwd_data, 32'hA);
    tick();
    in_valid = 1'b0;
    chk("fwd_pending", rd1_pending, 1'b1);
    chk("fwd_youngest", rd1_fwd_data, 32'hB);
    chk("fwd_miss_pending", rd2_pending, 1'b0);
    chk("fwd_miss_data", rd2_fwd_data, 32'd0);
    rf_stall = 1'b0;
    #1;
    chk("head_we", rf_write_enabled, 1'b1);
    chk("head_pending", rd1_pending, 1'b1);
    chk("head_fwd", rd1_fwd_data, 32'hB);
    tick();
    tick();
    chk("fwd_clear_pending", rd1_pending, 1'b0);
    chk("fwd_clear_data", rd1_fwd_data, 32'd0);

    // Location 0: handshake completes but nothing is queued.
    rf_stall     = 1'b1;
    rd1_location = 5'd0;
    in_valid     = 1'b1;
    in_location  = 5'd0;
    in_data      = 32'hFFFF;
    #1;
    chk("zero_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("zero_accepted", accepted, 1'b1);
    chk("zero_count", count, 3'd0);
    chk("zero_pending", rd1_pending, 1'b0);
    chk("zero_fwd", rd1_fwd_data, 32'd0);
    rf_stall = 1'b0;
    tick();

    // Full queue, stall released with a continuous stream of 8 writes.
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(10 + i), 32'(32'hA0 + i));
    in_valid    = 1'b1;
    in_location = 5'd16;
    in_data     = 32'hB0;
    rf_stall    = 1'b0;
    #1;
    chk("stream_ready_low", in_ready, 1'b0);
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      tick();
      chk("stream_count", count, 3'd3);
      if (accepted) begin
        idx++;
        in_location = 5'(16 + idx);
        in_data     = 32'(32'hB0 + idx);
      end
    end
    in_valid = 1'b0;
    chk("stream_done", 64'(idx), 64'd8);
    for (int c = 0; c < 20 && count != 3'd0; c++) tick();
    chk("stream_drained", count, 3'd0);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with three writes queued.
    rf_stall = 1'b1;
    push(5'd3, 32'h301);
    push(5'd4, 32'h401);
    push(5'd6, 32'h601);
    rd1_location = 5'd3;
    chk("pre_rst_count", count, 3'd3);
    rf_stall = 1'b0;
    #1;
    chk("pre_rst_we", rf_write_enabled, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", rf_write_enabled, 1'b0);
    chk("arst_count", count, 3'd0);
    chk("arst_pending", rd1_pending, 1'b0);
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_count", count, 3'd0);
    chk("post_rst_pending", rd1_pending, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end for the `memory` register file. It buffers register write-back requests from the execute/load path in a small FIFO and drains them, one per cycle, onto the register file's single write port.
- It also gives decode a lookup on two read locations: pending-hazard flags plus forwarded data from the youngest queued write. Decode then sees a coherent register value before the write commits.

Parameters:
- WIDTH, 32, data width; must match the register file WIDTH.
- ADDR_W, 5, register location width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept this cycle.
- in_location  in  ADDR_W  destination register.
- in_data  in  WIDTH  value to write.
- rf_stall  in  1  register file write port unavailable this cycle.
- rf_write_enabled  out  1  drives the register file write_enabled.
- rf_write_location  out  ADDR_W  drives the register file write_location.
- rf_write_data  out  WIDTH  drives the register file write_data.
- rd1_location  in  ADDR_W  decode read port 1 location.
- rd1_pending  out  1  a queued write targets rd1_location.
- rd1_fwd_data  out  WIDTH  data of the youngest matching entry; 0 if none.
- rd2_location  in  ADDR_W  decode read port 2 location.
- rd2_pending  out  1  a queued write targets rd2_location.
- rd2_fwd_data  out  WIDTH  data of the youngest matching entry; 0 if none.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync release):
  - head, tail and count are set to 0.
  - All entry valid bits are cleared.
  - Outputs after reset: in_ready=1, rf_write_enabled=0, rf_write_location=0, rf_write_data=0, rdN_pending=0, rdN_fwd_data=0.
- Handshake and enqueue:
  - in_ready = (count != DEPTH). Asserting in_ready does not depend on a pop in the same cycle.
  - A push occurs when in_valid && in_ready.
  - A request with in_location==0 is accepted (handshake completes) but is not enqueued: register 0 stays constant zero.
- Drain:
  - rf_write_enabled = (count != 0) && !rf_stall. This is combinational from the head entry.
  - rf_write_location and rf_write_data equal the head entry when count!=0, else 0.
  - A pop occurs on the same posedge that the register file captures the write.
- Latency: a request accepted at edge N is presented on the rf_* outputs in cycle N+1 if the queue was empty and no stall is present. The register file is updated at edge N+1.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - When full, push is blocked even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count saturates in range 0..DEPTH; an overflow or underflow is an assertion failure.
- rf_stall held for many cycles: the queue fills and in_ready drops; contents are preserved.
- Forwarding:
  - Combinational search of all valid entries for a match with rdN_location, prioritised by age from tail-1 back to head. The youngest match wins.
  - rdN_location==0 always yields pending=0 and fwd_data=0.
  - The head entry being written this cycle still counts as pending. After the pop, the register file holds that value.
  - A request entering this cycle is not visible until the next cycle. There is no in_* to rd* bypass.
- Reset mid-operation drops all queued writes. No partial write is issued.
- Ordering: writes to the same location commit in acceptance order.

Decomposition:
- Shared package `riscv_pkg`: REG_ADDR_W=5, XLEN=32, and a `wb_entry_t` struct {location, data}.
- One sub-module, `wq_fifo`: storage, pointers, count and per-entry valid. It exposes all entries read-only for the lookup.
- Forwarding match logic lives in the top, instantiated twice via a function.

Test Plan:
- Reset with in_valid=1: in_ready=1, rf_write_enabled=0, count=0. Release reset, push (loc 5, 0xDEADBEEF): next cycle rf_write_enabled=1, loc=5, data=0xDEADBEEF; count returns to 0 after that edge.
- rf_stall=1, push 4 writes (loc 1..4, data 0x11..0x44): count=4, in_ready=0. A 5th push is not accepted. Release the stall: writes issue in order 1,2,3,4 on consecutive cycles.
- rf_stall=1, push loc 7=0xA then loc 7=0xB, set rd1_location=7: rd1_pending=1, rd1_fwd_data=0xB. rd2_location=8 gives pending=0, fwd=0.
- Push loc 0 data 0xFFFF: handshake completes, count stays 0, no rf write. rd1_location=0 gives pending=0.
- Full queue with rf_stall=0 and in_valid=1 continuously: in_ready=0 for 1 cycle, then push and pop coexist with count steady; an 8-write stream exercises wrap-around in order.
- Reset asserted asynchronously mid-cycle with 3 entries queued: rf_write_enabled=0 immediately, count=0, and no stale write appears after release.
